// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control state machine for the stopwatch. It turns the debounced start/stop
// and lap/reset button levels into one-cycle strobes and steady levels for the
// time counter, the lap capture register and the display mux. A captured lap
// stays on the display for LAP_HOLD_TICKS timebase ticks.
//
// Parameters:
//   LAP_HOLD_TICKS  ticks a captured lap stays on the display (1..4095)
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   btn_ss    in   debounced start/stop button level
//   btn_lr    in   debounced lap/reset button level
//   tick      in   one-cycle timebase pulse (100 Hz enable)
//   run       out  count enable for the time counter
//   cnt_clr   out  one-cycle clear strobe for the time counter
//   lap_load  out  one-cycle capture strobe for the lap register
//   lap_clr   out  one-cycle clear strobe for the lap register
//   disp_lap  out  high selects lap digits, low selects live digits
//   lap_num   out  laps taken since the last clear (saturates at 15)
//   state     out  IDLE=0, RUN=1, LAP_VIEW=2, PAUSE=3
module stopwatch_ctrl #(
  parameter int LAP_HOLD_TICKS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       tick,
  output logic       run,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       lap_clr,
  output logic       disp_lap,
  output logic [3:0] lap_num,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    LAP_VIEW = 2'd2,
    PAUSE    = 2'd3
  } state_t;

  localparam logic [11:0] HOLD_INIT = 12'(LAP_HOLD_TICKS);

  state_t      cur;
  logic        ss_prev;
  logic        lr_prev;
  logic [11:0] hold_cnt;
  logic        ss_press;
  logic        lr_press;
  logic [3:0]  lap_next;

  // Rising-edge detection. The prev copies reset to 1, so a button held
  // through reset must be released and pressed again to register.
  assign ss_press = btn_ss & ~ss_prev;
  assign lr_press = btn_lr & ~lr_prev;

  // Lap counter saturates at 15; lap_load still pulses beyond that.
  assign lap_next = (lap_num == 4'hF) ? lap_num : lap_num + 4'd1;

  assign state = cur;

  // Single registered FSM. Strobes default low every cycle so each press
  // yields exactly one cycle of strobe. Start/stop is checked before
  // lap/reset in every state, which drops a coincident lap/reset press.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= IDLE;
      run      <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_load <= 1'b0;
      lap_clr  <= 1'b0;
      disp_lap <= 1'b0;
      lap_num  <= 4'd0;
      hold_cnt <= 12'd0;
      ss_prev  <= 1'b1;
      lr_prev  <= 1'b1;
    end else begin
      ss_prev  <= btn_ss;
      lr_prev  <= btn_lr;
      cnt_clr  <= 1'b0;
      lap_load <= 1'b0;
      lap_clr  <= 1'b0;

      case (cur)
        IDLE, PAUSE: begin
          if (ss_press) begin
            cur      <= RUN;
            run      <= 1'b1;
            disp_lap <= 1'b0;
          end else if (lr_press) begin
            cur      <= IDLE;
            run      <= 1'b0;
            disp_lap <= 1'b0;
            cnt_clr  <= 1'b1;
            lap_clr  <= 1'b1;
            lap_num  <= 4'd0;
          end
        end

        RUN: begin
          if (ss_press) begin
            cur      <= PAUSE;
            run      <= 1'b0;
            disp_lap <= 1'b0;
          end else if (lr_press) begin
            cur      <= LAP_VIEW;
            run      <= 1'b1;
            disp_lap <= 1'b1;
            lap_load <= 1'b1;
            lap_num  <= lap_next;
            hold_cnt <= HOLD_INIT;
          end
        end

        LAP_VIEW: begin
          // Pause beats expiry; a re-lap reload beats a coincident tick.
          if (ss_press) begin
            cur      <= PAUSE;
            run      <= 1'b0;
            disp_lap <= 1'b0;
          end else if (lr_press) begin
            lap_load <= 1'b1;
            lap_num  <= lap_next;
            hold_cnt <= HOLD_INIT;
          end else if (tick) begin
            if (hold_cnt != 12'd0) begin
              hold_cnt <= hold_cnt - 12'd1;
            end
            if (hold_cnt <= 12'd1) begin
              cur      <= RUN;
              run      <= 1'b1;
              disp_lap <= 1'b0;
            end
          end
        end

        default: begin
          cur      <= IDLE;
          run      <= 1'b0;
          disp_lap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl. Directed sequences walk the main
// scenarios, then random button/tick/reset activity runs against a
// behavioural model of the stopwatch written in terms of laps taken and
// ticks remaining on the lap display.
module tb_stopwatch_ctrl;

  localparam int HOLD = 3;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic       tick;
  logic       run;
  logic       cnt_clr;
  logic       lap_load;
  logic       lap_clr;
  logic       disp_lap;
  logic [3:0] lap_num;
  logic [1:0] state;

  int nChecks;
  int nFails;

  // Reference model: what the user sees, kept as a mode, an unbounded lap
  // count and the ticks left before the lap display lapses.
  int mode;        // 0 idle, 1 running, 2 showing a lap, 3 paused
  int lapsTaken;
  int ticksLeft;
  bit ssWasHigh;
  bit lrWasHigh;
  bit expCntClr;
  bit expLapLoad;
  bit expLapClr;

  stopwatch_ctrl #(.LAP_HOLD_TICKS(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .tick     (tick),
    .run      (run),
    .cnt_clr  (cnt_clr),
    .lap_load (lap_load),
    .lap_clr  (lap_clr),
    .disp_lap (disp_lap),
    .lap_num  (lap_num),
    .state    (state)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled there.
  task automatic modelStep(input bit ss, input bit lr, input bit tk, input bit rs);
    bit ssPress;
    bit lrPress;
    expCntClr  = 1'b0;
    expLapLoad = 1'b0;
    expLapClr  = 1'b0;
    if (rs) begin
      mode      = 0;
      lapsTaken = 0;
      ticksLeft = 0;
      ssWasHigh = 1'b1;
      lrWasHigh = 1'b1;
      return;
    end
    ssPress   = ss && !ssWasHigh;
    lrPress   = lr && !lrWasHigh;
    ssWasHigh = ss;
    lrWasHigh = lr;
    if (ssPress) begin
      mode = (mode == 1 || mode == 2) ? 3 : 1;
    end else if (lrPress) begin
      if (mode == 1 || mode == 2) begin
        expLapLoad = 1'b1;
        lapsTaken++;
        ticksLeft = HOLD;
        mode = 2;
      end else begin
        expCntClr = 1'b1;
        expLapClr = 1'b1;
        lapsTaken = 0;
        mode = 0;
      end
    end else if (tk && mode == 2) begin
      ticksLeft--;
      if (ticksLeft == 0) mode = 1;
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare after it.
  task automatic applyStimulus(input bit ss, input bit lr, input bit tk, input bit rs);
    @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    tick   = tk;
    rst    = rs;
    @(posedge clk);
    modelStep(ss, lr, tk, rs);
    #1;
    checkOutput("state",    32'(state),    32'(mode));
    checkOutput("run",      32'(run),      32'(mode == 1 || mode == 2));
    checkOutput("disp_lap", 32'(disp_lap), 32'(mode == 2));
    checkOutput("lap_num",  32'(lap_num),  32'(lapsTaken > 15 ? 15 : lapsTaken));
    checkOutput("cnt_clr",  32'(cnt_clr),  32'(expCntClr));
    checkOutput("lap_load", 32'(lap_load), 32'(expLapLoad));
    checkOutput("lap_clr",  32'(lap_clr),  32'(expLapClr));
    checkOutput("excl",     32'(lap_load & (lap_clr | cnt_clr)), 32'd0);
  endtask

  initial begin
    bit ss;
    bit lr;
    nChecks   = 0;
    nFails    = 0;
    mode      = 0;
    lapsTaken = 0;
    ticksLeft = 0;
    ssWasHigh = 1'b1;
    lrWasHigh = 1'b1;
    btn_ss = 1'b1;
    btn_lr = 1'b0;
    tick   = 1'b0;
    rst    = 1'b1;

    // Reset with start/stop held: no press until release and re-press.
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);

    // Lap from RUN, then the display lapses after exactly HOLD ticks.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);

    // Re-lap coincident with the expiring tick reloads the hold count.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);

    // Both buttons rise together in RUN: pause wins, no lap taken.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Lap/reset in PAUSE clears and returns to IDLE.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Sixteen laps saturate the lap count at 15.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end

    // Reset mid-LAP_VIEW returns to IDLE with no strobes.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    // Random button activity with frequent ticks and occasional resets.
    ss = 1'b0;
    lr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ss = ~ss;
      if ($urandom_range(0, 3) == 0) lr = ~lr;
      applyStimulus(ss, lr, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control state machine for the stopwatch. It turns the debounced start/stop and lap/reset buttons into one-cycle strobes and levels for the time counter, the lap capture register and the display mux. Lap values are held on the display for a programmable number of ticks. It sits between the button debouncers and the counter / lap-register / seven-segment datapath.

## Interface
- LAP_HOLD_TICKS, 300: number of `tick` pulses a captured lap stays on the display (legal range 1..4095).
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_ss  input  1  debounced start/stop button level.
- btn_lr  input  1  debounced lap/reset button level.
- tick  input  1  one-cycle timebase pulse (100 Hz enable).
- run  output  1  count enable for the time counter.
- cnt_clr  output  1  one-cycle clear strobe for the time counter.
- lap_load  output  1  one-cycle capture strobe for the lap register.
- lap_clr  output  1  one-cycle clear strobe for the lap register.
- disp_lap  output  1  high selects lap digits on the display; low selects live digits.
- lap_num  output  4  count of laps taken since the last clear.
- state  output  2  current state: IDLE=0, RUN=1, LAP_VIEW=2, PAUSE=3.

## Operation
- Press detection:
  - ss_press = btn_ss & ~ss_prev; lr_press = btn_lr & ~lr_prev.
  - ss_prev and lr_prev are registered copies of the buttons, set to 1 by rst, so a button held through reset gives no press until it is released and pressed again.
- Priority: if ss_press and lr_press occur in the same cycle, ss_press is acted on and lr_press is dropped.
- IDLE (run=0, disp_lap=0):
  - ss_press -> RUN.
  - lr_press -> pulse cnt_clr and lap_clr, set lap_num=0, stay in IDLE.
- RUN (run=1, disp_lap=0):
  - ss_press -> PAUSE.
  - lr_press -> pulse lap_load, lap_num+1 (saturates at 15), hold_cnt=LAP_HOLD_TICKS, -> LAP_VIEW.
- LAP_VIEW (run=1, disp_lap=1):
  - On each tick, hold_cnt decrements. A tick while hold_cnt==1 -> RUN.
  - lr_press -> pulse lap_load, lap_num+1 (saturating), reload hold_cnt, stay in LAP_VIEW. The reload wins over a coincident tick.
  - ss_press -> PAUSE. This wins over a coincident expiry.
- PAUSE (run=0, disp_lap=0):
  - ss_press -> RUN.
  - lr_press -> pulse cnt_clr and lap_clr, set lap_num=0, -> IDLE.
- Strobe exclusivity:
  - lap_load is never asserted in the same cycle as lap_clr or cnt_clr.
  - Each strobe lasts exactly one clk cycle per press.
- hold_cnt: 12-bit unsigned. It is loaded only on entry to LAP_VIEW or on re-lap, is frozen outside LAP_VIEW, and never wraps below 0.
- lap_num saturation: stays at 15 on further laps; lap_load still pulses.

## Timing
- All outputs are registered. State, strobes and levels change at the clock edge that samples the press, so they are visible one cycle after btn_* first reads high.
- Reset values: run=0, cnt_clr=0, lap_load=0, lap_clr=0, disp_lap=0, lap_num=0, state=IDLE, hold_cnt=0, ss_prev=1, lr_prev=1.
- rst has priority over every other input. rst in any state, including mid-LAP_VIEW, returns to IDLE on the next edge with no strobes issued.
- Lap display duration: exactly LAP_HOLD_TICKS tick pulses after the lap_load cycle. The first counted tick is the first tick after the load edge.
- Re-entry: a release and re-press needs at least one cycle with the button low between the two presses.
- tick has no effect outside LAP_VIEW.

## Test plan
- Reset with btn_ss held high, then release and press -> no press before the release; after the press, state=RUN and run=1 one cycle after btn_ss rises.
- RUN, press lr, LAP_HOLD_TICKS=3 -> lap_load high for 1 cycle, lap_num=1, disp_lap=1; after the 3rd tick, state=RUN and disp_lap=0; run stays 1 throughout.
- LAP_VIEW, lr_press in the same cycle as the expiring tick -> stays in LAP_VIEW, lap_num=2, hold_cnt=3, second lap_load pulse.
- RUN, btn_ss and btn_lr rise in the same cycle -> state=PAUSE, no lap_load, lap_num unchanged.
- PAUSE, press lr -> cnt_clr=1 and lap_clr=1 for 1 cycle, lap_num=0, state=IDLE; 16 laps from RUN -> lap_num saturates at 15.
- LAP_VIEW, assert rst for 1 cycle -> next cycle state=IDLE, all outputs 0, no strobes.
